scan01_ctrl: RTL and testbench
==============================

# scan01_ctrl

Word-level sequencer for the serial "01" pattern detector. Accepts a parallel WIDTH-bit word through a start/ready handshake, feeds it MSB-first one bit per clock through an internal two-state detector, and counts overlapping "01" occurrences. It reports the count with a one-cycle done pulse. It sits between a parallel producer and the bit-serial detection logic, so the producer never has to drive the serial stream itself.

## Interface
- WIDTH, 8, word length in bits; must be ≥ 2.
- CNT_W, 4, count width; must satisfy 2^CNT_W > WIDTH/2 + 1.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to scan din; sampled only in IDLE.
- din  input  WIDTH  word to scan; captured on the accepting edge.
- abort  input  1  synchronous cancel; effective only in SHIFT.
- ready  output  1  high exactly when state is IDLE.
- sx  output  1  bit currently presented to the detector (shift register MSB).
- done  output  1  one-cycle pulse; count is final.
- count  output  CNT_W  number of "01" occurrences in the last scanned word.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: state=IDLE, ready=1, done=0, count=0, sx=0, shift register=0, bit counter=0, last0=0.
- IDLE, start=1:
  - Load shift register with din.
  - Set bit counter to WIDTH-1.
  - Clear count.
  - Clear last0 (see Configuration).
  - Go to SHIFT.
- SHIFT, each cycle:
  - b = shift register MSB, also driven on sx.
  - If last0=1 and b=1, increment count.
  - last0 <= ~b.
  - Shift left by one, filling with 0.
  - Decrement bit counter.
  - After the bit with counter=0 is processed, go to DONE.
- DONE: done=1 for this one cycle, then go to IDLE.
- count holds its value in DONE and IDLE until the next accepted start.
- abort=1 in SHIFT: go to IDLE next edge, count <= 0, last0 <= 0, no done. abort is ignored in IDLE and DONE.
- start outside IDLE is ignored, with no queuing.
- Counting is overlap-safe. A "1" resets the pending-zero condition; a "0" arms it.
- count never wraps because the parameter constraint guarantees headroom. Increments are plain unsigned adds.

## Timing
- Edge E0 (IDLE, start=1) accepts the word; ready falls after E0.
- Edges E1..E_WIDTH process bits din[WIDTH-1]..din[0].
- count reflects the bit processed at edge Ek immediately after Ek.
- done is high between E_WIDTH and E_WIDTH+1.
- ready rises after E_WIDTH+1.
- Accept-to-done latency is WIDTH cycles. Throughput is one word per WIDTH+2 cycles when start is held high.
- Asserting rst forces all outputs to reset values immediately, regardless of clk, including mid-SHIFT. Release takes effect at the next edge.
- abort and the final bit on the same edge: abort wins, so state goes to IDLE, count=0, and done is not raised.

## Configuration
- SCAN_CHAIN_EN:
  - Defined: last0 is not cleared on start. A trailing 0 of word N and a leading 1 of word N+1 count as one occurrence in word N+1. last0 is cleared only by rst or abort.
  - Undefined: last0 is cleared on every accepted start, so each word is scanned independently and its first bit can never complete a match.

## Test plan
- din=8'b01010101, start one cycle → done exactly 8 cycles after accepting edge, count=4, sx sequence 0,1,0,1,0,1,0,1.
- din=8'h00, then din=8'hFF → count=0 both times. din=8'b00110011 → count=2.
- Word 8'b11110000, then word 8'b10000000 → second count=0 without SCAN_CHAIN_EN, 1 with it. First count=0 in both builds.
- start held high, din=8'b01010101 → done every 10 cycles, ready low for 9 cycles between acceptances, start pulses during SHIFT ignored.
- din=8'b01010101, abort at third SHIFT cycle → no done, count=0, ready=1 next cycle, then a fresh start scans normally (count=4).
- rst asserted between edges mid-SHIFT → ready=1, done=0, count=0, sx=0 immediately. After release, start with din=8'b00000001 → count=1.

Source files
------------

// File: rtl/scan01_ctrl.sv
// Word-level sequencer: scans a WIDTH-bit word MSB-first and counts overlapping "01" pairs.
// Optional macro SCAN_CHAIN_EN lets a trailing 0 of one word pair with a leading 1 of the next.
module scan01_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic             abort,
   output logic             ready,
   output logic             sx,
   output logic             done,
   output logic [CNT_W-1:0] count
);

   localparam int BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             last0_q, last0_d;
   logic             b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         count_q   <= '0;
         last0_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         count_q   <= count_d;
         last0_q   <= last0_d;
      end
   end

   assign b = sr_q[WIDTH-1];

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      count_d   = count_q;
      last0_d   = last0_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sr_d      = din;
               bit_cnt_d = BCW'(WIDTH - 1);
               count_d   = '0;
`ifdef SCAN_CHAIN_EN
               last0_d   = last0_q;
`else
               last0_d   = 1'b0;
`endif
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // abort outranks the final bit, so a cancelled word never signals done
            if (abort) begin
               sr_d    = '0;
               count_d = '0;
               last0_d = 1'b0;
               state_d = IDLE;
            end else begin
               if (last0_q && b) begin
                  count_d = count_q + CNT_W'(1);
               end
               last0_d   = ~b;
               sr_d      = {sr_q[WIDTH-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q - BCW'(1);
               if (bit_cnt_q == '0) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ready = (state_q == IDLE);
   assign done  = (state_q == DONE);
   assign sx    = b;
   assign count = count_q;

endmodule

// File: tb/tb_scan01_ctrl.sv
// Directed self-checking bench for scan01_ctrl; expected counts are hand-computed.
// Honours SCAN_CHAIN_EN so the chained-word expectation matches the build.
module tb_scan01_ctrl;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] din;
   logic             abort;
   logic             ready;
   logic             sx;
   logic             done;
   logic [CNT_W-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   scan01_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din),
      .abort (abort),
      .ready (ready),
      .sx    (sx),
      .done  (done),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one active edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitReady();
      int k;
      k = 0;
      while (ready !== 1'b1 && k < 50) begin
         step();
         k++;
      end
      if (ready !== 1'b1) checkOutput("ready_timeout", {31'd0, ready}, 32'd1);
   endtask

   // accept a word, follow it bit by bit, then check done timing and count
   task automatic applyStimulus(input logic [WIDTH-1:0] word, input int exp_count, input string tag);
      waitReady();
      din   = word;
      start = 1'b1;
      step();
      start = 1'b0;
      checkOutput({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
      for (int k = 1; k <= WIDTH; k++) begin
         checkOutput({tag, "_sx"}, {31'd0, sx}, {31'd0, word[WIDTH-k]});
         checkOutput({tag, "_no_early_done"}, {31'd0, done}, 32'd0);
         step();
      end
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
      checkOutput({tag, "_count"}, {28'd0, count}, exp_count);
      step();
      checkOutput({tag, "_done_fall"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_ready_rise"}, {31'd0, ready}, 32'd1);
      checkOutput({tag, "_count_hold"}, {28'd0, count}, exp_count);
   endtask

   initial begin
      int exp_chain;
`ifdef SCAN_CHAIN_EN
      exp_chain = 1;
`else
      exp_chain = 0;
`endif
      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      abort = 1'b0;
      #1;
      checkOutput("rst_ready", {31'd0, ready}, 32'd1);
      checkOutput("rst_done",  {31'd0, done},  32'd0);
      checkOutput("rst_count", {28'd0, count}, 32'd0);
      checkOutput("rst_sx",    {31'd0, sx},    32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      applyStimulus(8'b01010101, 4, "alt");
      applyStimulus(8'h00, 0, "zeros");
      applyStimulus(8'hFF, 0, "ones");
      applyStimulus(8'b00110011, 2, "pairs");
      applyStimulus(8'b11110000, 0, "chain_a");
      applyStimulus(8'b10000000, exp_chain, "chain_b");

      // start held high: done every WIDTH+2 cycles, ready low WIDTH+1 cycles
      waitReady();
      din   = 8'b01010101;
      start = 1'b1;
      step();
      for (int c = 1; c < 30; c++) begin
         step();
         checkOutput("held_done",  {31'd0, done},  ((c % 10) == 8) ? 32'd1 : 32'd0);
         checkOutput("held_ready", {31'd0, ready}, ((c % 10) == 9) ? 32'd1 : 32'd0);
         if ((c % 10) == 8) checkOutput("held_count", {28'd0, count}, 32'd4);
      end
      start = 1'b0;

      // abort sampled on the third shift edge
      waitReady();
      din   = 8'b01010101;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      checkOutput("abort_pre_count", {28'd0, count}, 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      checkOutput("abort_ready", {31'd0, ready}, 32'd1);
      checkOutput("abort_count", {28'd0, count}, 32'd0);
      checkOutput("abort_done",  {31'd0, done},  32'd0);
      step();
      checkOutput("abort_no_done", {31'd0, done}, 32'd0);
      applyStimulus(8'b01010101, 4, "after_abort");

      // asynchronous reset between edges in the middle of a scan
      waitReady();
      din   = 8'b01010101;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      checkOutput("mid_count", {28'd0, count}, 32'd1);
      checkOutput("mid_sx",    {31'd0, sx},    32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_ready", {31'd0, ready}, 32'd1);
      checkOutput("arst_done",  {31'd0, done},  32'd0);
      checkOutput("arst_count", {28'd0, count}, 32'd0);
      checkOutput("arst_sx",    {31'd0, sx},    32'd0);
      step();
      rst = 1'b0;
      step();
      applyStimulus(8'b00000001, 1, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
